// File: rtl/md_sequencer_if.sv
// Bundle of the MD issue/result signals shared between the pipeline and md_sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        md_d;
    logic        cancel;
    logic        busy;
    logic        stall_md;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, d1, d2, md_d, cancel,
        input  busy, stall_md, done, hi, lo
    );

    modport slave (
        input  start, op, d1, d2, md_d, cancel,
        output busy, stall_md, done, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide unit holding the HI/LO registers.
// mult/multu take 5 busy cycles and div/divu take 10.
// mthi/mtlo write HI/LO directly in a single cycle.
// The optional abort path is enabled by defining MD_SEQUENCER_CANCEL_EN.
// With that macro undefined, the cancel input is ignored.
module md_sequencer (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic        [3:0]  cnt_q, cnt_d;
    logic        [31:0] op_a_q, op_a_d;
    logic        [31:0] op_b_q, op_b_d;
    logic               is_signed_q, is_signed_d;
    logic        [31:0] hi_q, hi_d;
    logic        [31:0] lo_q, lo_d;

    logic               cancel_req;
    logic               busy_w;
    logic               done_w;
    logic        [63:0] mul_a, mul_b, product;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic        [31:0] div_q, div_r;

`ifdef MD_SEQUENCER_CANCEL_EN
    assign cancel_req = bus.cancel;
`else
    assign cancel_req = bus.cancel & 1'b0;
`endif

    // Arithmetic on the latched operands; the result is only used at the commit cycle.
    always_comb begin
        mul_a   = is_signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
        mul_b   = is_signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
        product = mul_a * mul_b;
        quot_s  = $signed(op_a_q) / $signed(op_b_q);
        rem_s   = $signed(op_a_q) % $signed(op_b_q);
        quot_u  = op_a_q / op_b_q;
        rem_u   = op_a_q % op_b_q;
        div_q   = is_signed_q ? quot_s : quot_u;
        div_r   = is_signed_q ? rem_s : rem_u;
    end

    // Next-state logic: issue from IDLE, count down in MUL/DIV, commit at zero.
    // An abort takes priority over the commit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        is_signed_d = is_signed_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_w      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !cancel_req) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            op_a_d      = bus.d1;
                            op_b_d      = bus.d2;
                            is_signed_d = ~bus.op[0];
                            cnt_d       = 4'd4;
                            state_d     = MUL;
                        end
                        3'd2, 3'd3: begin
                            op_a_d      = bus.d1;
                            op_b_d      = bus.d2;
                            is_signed_d = ~bus.op[0];
                            cnt_d       = 4'd9;
                            state_d     = DIV;
                        end
                        3'd4:    hi_d = bus.d1;
                        3'd5:    lo_d = bus.d1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cancel_req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    done_w  = 1'b1;
                    state_d = IDLE;
                    if (state_q == MUL) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (op_b_q != 32'd0) begin
                        hi_d = div_r;
                        lo_d = div_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            is_signed_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            is_signed_q <= is_signed_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy_w       = (state_q != IDLE);
    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.stall_md = (bus.start | busy_w) & bus.md_d;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer.
// The reference model computes products, quotients and remainders with 64-bit integer arithmetic.
// From those it derives the expected latency, done timing and HI/LO contents.
module tb_md_sequencer;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    md_sequencer_if bus ();

    md_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Issue one operation and follow it through to completion.
    // Inputs are driven at the falling edge, and outputs are sampled 1 ns later.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic md, input logic spurious);
        logic [31:0] n_hi, n_lo;
        longint      la, lb, mq, q, r, p;
        longint unsigned pu;
        int          lat;
        logic        md_now;
        n_hi = exp_hi;
        n_lo = exp_lo;
        lat  = 0;
        case (op)
            3'd0: begin
                la = {{32{a[31]}}, a};
                lb = {{32{b[31]}}, b};
                p  = la * lb;
                n_hi = p[63:32];
                n_lo = p[31:0];
                lat = 5;
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                n_hi = pu[63:32];
                n_lo = pu[31:0];
                lat = 5;
            end
            3'd2, 3'd3: begin
                if (op == 3'd2) begin
                    la = {{32{a[31]}}, a};
                    lb = {{32{b[31]}}, b};
                end else begin
                    la = {32'd0, a};
                    lb = {32'd0, b};
                end
                if (lb != 0) begin
                    mq = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
                    q  = ((la < 0) != (lb < 0)) ? -mq : mq;
                    r  = la - q * lb;
                    n_lo = q[31:0];
                    n_hi = r[31:0];
                end
                lat = 10;
            end
            3'd4: n_hi = a;
            3'd5: n_lo = a;
            default: ;
        endcase

        bus.start = 1'b1;
        bus.op    = op;
        bus.d1    = a;
        bus.d2    = b;
        bus.md_d  = md;
        #1;
        checks++;
        if (bus.stall_md !== md) begin
            errors++;
            $display("[TB] FAIL stall_issue op=%0d: got %b expected %b", op, bus.stall_md, md);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_issue op=%0d: got %b expected 0", op, bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.d1    = $urandom;
        bus.d2    = $urandom;

        for (int i = 1; i <= lat; i++) begin
            md_now    = 1'($urandom_range(0, 1));
            bus.md_d  = md_now;
            bus.start = spurious && (i == 2);
            bus.op    = 3'd4;
            #1;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_cycle%0d op=%0d: got %b expected 1", i, op, bus.busy);
            end
            checks++;
            if (bus.done !== (i == lat)) begin
                errors++;
                $display("[TB] FAIL done_cycle%0d op=%0d: got %b expected %b", i, op, bus.done, (i == lat));
            end
            checks++;
            if (bus.stall_md !== md_now) begin
                errors++;
                $display("[TB] FAIL stall_busy%0d: got %b expected %b", i, bus.stall_md, md_now);
            end
            checks++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++;
                $display("[TB] FAIL hilo_hold%0d: got %h_%h expected %h_%h", i, bus.hi, bus.lo, exp_hi, exp_lo);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end

        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after op=%0d: got busy=%b done=%b expected 0 0", op, bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== n_hi || bus.lo !== n_lo) begin
            errors++;
            $display("[TB] FAIL result op=%0d a=%h b=%h: got %h_%h expected %h_%h",
                     op, a, b, bus.hi, bus.lo, n_hi, n_lo);
        end
        exp_hi = n_hi;
        exp_lo = n_lo;
        @(negedge clk);
    endtask

    // Reset asserted from time zero; all outputs must be cleared.
    task automatic test_reset();
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.d1     = 32'd0;
        bus.d2     = 32'd0;
        bus.md_d   = 1'b0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Directed vectors with known answers.
    task automatic test_directed();
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL mult_vec: got %h_%h expected ffffffff_fffffffe", bus.hi, bus.lo);
        end
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        checks++;
        if (bus.hi !== 32'h00000001 || bus.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL multu_vec: got %h_%h expected 00000001_fffffffe", bus.hi, bus.lo);
        end
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL div_vec: got %h_%h expected ffffffff_fffffffd", bus.hi, bus.lo);
        end
        run_op(3'd3, 32'd1234, 32'd0, 1'b1, 1'b0);
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL divu_zero: got %h_%h expected ffffffff_fffffffd", bus.hi, bus.lo);
        end
        run_op(3'd4, 32'h12345678, 32'd0, 1'b1, 1'b0);
        checks++;
        if (bus.hi !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL mthi_vec: got %h expected 12345678", bus.hi);
        end
        run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
        run_op(3'd7, 32'h0BADBEEF, 32'd1, 1'b1, 1'b0);
    endtask

    // Randomized operations, with divisors biased toward small, negative and zero values.
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                default: ;
            endcase
            if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Reset pulled low in the third busy cycle of a divide.
    task automatic test_reset_mid_div();
        run_op(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
        run_op(3'd5, 32'h5A5A5A5A, 32'd0, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.d1    = 32'd100;
        bus.d2    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_before_reset: got %b expected 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_div: got busy=%b done=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset  = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        run_op(3'd0, 32'd300, 32'd5, 1'b0, 1'b0);
    endtask

`ifdef MD_SEQUENCER_CANCEL_EN
    // Abort paths: cancel mid-mult, cancel on issue, and cancel on the commit cycle.
    task automatic test_cancel();
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.d1    = 32'd77;
        bus.d2    = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.cancel = 1'b1;
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cancel_cycle: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        bus.cancel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                errors++;
                $display("[TB] FAIL cancel_mult%0d: got busy=%b done=%b %h_%h expected 0 0 %h_%h",
                         i, bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
        bus.start  = 1'b1;
        bus.op     = 3'd4;
        bus.d1     = ~exp_hi;
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        #1;
        checks++;
        if (bus.hi !== exp_hi || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cancel_mthi: got hi=%h busy=%b expected %h 0", bus.hi, bus.busy, exp_hi);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.d1    = 32'd1000;
        bus.d2    = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cancel_commit: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        bus.cancel = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("[TB] FAIL cancel_commit_hilo: got busy=%b %h_%h expected 0 %h_%h",
                     bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask
`else
    // With the abort path compiled out, cancel held high must not disturb anything.
    task automatic test_cancel();
        bus.cancel = 1'b1;
        run_op(3'd0, 32'hFFFFFFFE, 32'd5, 1'b1, 1'b0);
        run_op(3'd5, 32'h01020304, 32'd0, 1'b0, 1'b0);
        bus.cancel = 1'b0;
    endtask
`endif

    // Run every scenario in sequence, then print the summary.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_div();
        test_cancel();
        run_op(3'd1, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
